// File: rtl/bit_count_pipe.sv
// Two-stage pipelined CLZ/CLO/CTZ/POPCNT unit with valid/ready handshake and flush.
// Stage 1 normalises the operand and reduces it to per-group run/pop counts; stage 2 sums them.
module bit_count_pipe #(
    parameter  int WIDTH = 32,
    parameter  int GROUP = 8,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_value,
    input  logic [4:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic [4:0]       out_tag,
    output logic             out_all
);

    localparam int N  = WIDTH / GROUP;
    localparam int GW = $clog2(GROUP) + 1;

    typedef enum logic [1:0] {
        OP_CLZ = 2'b00,
        OP_CLO = 2'b01,
        OP_CTZ = 2'b10,
        OP_POP = 2'b11
    } op_e;

    logic          s1_valid;
    op_e           s1_op;
    logic [4:0]    s1_tag;
    logic [GW-1:0] s1_run [N];
    logic [GW-1:0] s1_pop [N];
    logic          s2_valid;

    logic          s1_adv;
    logic          s2_adv;
    logic          accept;

    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] norm;
    logic [GW-1:0]    run_d [N];
    logic [GW-1:0]    pop_d [N];
    logic             seen;

    logic [CW-1:0]    lead_sum;
    logic [CW-1:0]    pop_sum;
    logic [CW-1:0]    count_d;
    logic             stop;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // Every op is reduced to counting leading ones (or plain ones for POPCNT).
    always_comb begin
        rev = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rev[i] = in_value[WIDTH-1-i];
        end
        case (op_e'(in_op))
            OP_CLZ:  norm = ~in_value;
            OP_CLO:  norm = in_value;
            OP_CTZ:  norm = ~rev;
            default: norm = in_value;
        endcase
        run_d = '{default: '0};
        pop_d = '{default: '0};
        seen  = 1'b0;
        for (int unsigned g = 0; g < N; g++) begin
            seen = 1'b0;
            for (int unsigned b = 0; b < GROUP; b++) begin
                if (norm[g*GROUP + GROUP - 1 - b]) begin
                    pop_d[g] = pop_d[g] + GW'(1);
                    if (!seen) begin
                        run_d[g] = run_d[g] + GW'(1);
                    end
                end else begin
                    seen = 1'b1;
                end
            end
        end
    end

    // Leading run continues into the next lower group only while groups are full.
    always_comb begin
        lead_sum = '0;
        pop_sum  = '0;
        stop     = 1'b0;
        for (int unsigned g = 0; g < N; g++) begin
            if (!stop) begin
                lead_sum = lead_sum + CW'(s1_run[N-1-g]);
                if (s1_run[N-1-g] != GW'(GROUP)) begin
                    stop = 1'b1;
                end
            end
            pop_sum = pop_sum + CW'(s1_pop[g]);
        end
        count_d = (s1_op == OP_POP) ? pop_sum : lead_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_CLZ;
            s1_tag    <= '0;
            s1_run    <= '{default: '0};
            s1_pop    <= '{default: '0};
            s2_valid  <= 1'b0;
            out_count <= '0;
            out_tag   <= '0;
            out_all   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_count <= count_d;
                    out_tag   <= s1_tag;
                    out_all   <= (count_d == CW'(WIDTH));
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (accept) begin
                    s1_op  <= op_e'(in_op);
                    s1_tag <= in_tag;
                    s1_run <= run_d;
                    s1_pop <= pop_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_count_pipe.sv
// Directed bench for bit_count_pipe: vector table at WIDTH=32 and WIDTH=64 plus
// hand-written backpressure, flush and asynchronous reset sequences.
module tb_bit_count_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_value;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_count;
    logic [4:0]  out_tag;
    logic        out_all;

    logic        w_valid;
    logic        w_ready;
    logic [1:0]  w_op;
    logic [63:0] w_value;
    logic [4:0]  w_tag;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [6:0]  w_count;
    logic [4:0]  w_out_tag;
    logic        w_all;

    int errors = 0;
    int checks = 0;

    bit_count_pipe #(.WIDTH(32), .GROUP(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_value(in_value), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_tag(out_tag), .out_all(out_all)
    );

    bit_count_pipe #(.WIDTH(64), .GROUP(8)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(w_valid), .in_ready(w_ready), .in_op(w_op),
        .in_value(w_value), .in_tag(w_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_count(w_count),
        .out_tag(w_out_tag), .out_all(w_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] value;
        logic [4:0]  tag;
        logic [5:0]  count;
        logic        all;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] value;
        logic [4:0]  tag;
        logic [6:0]  count;
        logic        all;
    } vec64_t;

    localparam int NV  = 13;
    localparam int NV64 = 4;
    vec_t   vt [NV];
    vec64_t wt [NV64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] val, input logic [4:0] tag);
        in_valid = v;
        in_op    = op;
        in_value = val;
        in_tag   = tag;
    endtask

    task automatic expect_out(input string name, input logic [5:0] cnt, input logic [4:0] tag, input logic all);
        chk({name, ".valid"}, out_valid, 1);
        chk({name, ".count"}, out_count, cnt);
        chk({name, ".tag"}, out_tag, tag);
        chk({name, ".all"}, out_all, all);
    endtask

    initial begin
        // op, value, tag, expected count, expected out_all
        vt[0]  = '{2'd0, 32'h0000_8000, 5'd1,  6'd16, 1'b0};
        vt[1]  = '{2'd1, 32'hFFF0_0000, 5'd2,  6'd12, 1'b0};
        vt[2]  = '{2'd2, 32'h0000_0100, 5'd3,  6'd8,  1'b0};
        vt[3]  = '{2'd3, 32'hF0F0_F0F0, 5'd4,  6'd16, 1'b0};
        vt[4]  = '{2'd0, 32'h0000_0000, 5'd5,  6'd32, 1'b1};
        vt[5]  = '{2'd1, 32'hFFFF_FFFF, 5'd6,  6'd32, 1'b1};
        vt[6]  = '{2'd2, 32'h8000_0000, 5'd7,  6'd31, 1'b0};
        vt[7]  = '{2'd3, 32'h0000_0000, 5'd8,  6'd0,  1'b0};
        vt[8]  = '{2'd1, 32'h7FFF_FFFF, 5'd9,  6'd0,  1'b0};
        vt[9]  = '{2'd2, 32'hFFFF_FFFF, 5'd10, 6'd0,  1'b0};
        vt[10] = '{2'd0, 32'h00FF_0000, 5'd11, 6'd8,  1'b0};
        vt[11] = '{2'd3, 32'hFFFF_FFFF, 5'd12, 6'd32, 1'b1};
        vt[12] = '{2'd0, 32'h0000_0001, 5'd31, 6'd31, 1'b0};

        wt[0] = '{2'd0, 64'h0000_0000_0000_0001, 5'd1, 7'd63, 1'b0};
        wt[1] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 7'd64, 1'b1};
        wt[2] = '{2'd2, 64'h8000_0000_0000_0000, 5'd3, 7'd63, 1'b0};
        wt[3] = '{2'd1, 64'hFFFF_FFFF_0000_0000, 5'd4, 7'd32, 1'b0};

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        w_out_ready = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 5'd0);
        w_valid = 1'b0; w_op = 2'd0; w_value = '0; w_tag = '0;

        #12;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.out_count", out_count, 0);
        chk("reset.out_tag", out_tag, 0);
        chk("reset.out_all", out_all, 0);
        chk("reset.in_ready", in_ready, 1);
        chk("reset.w_out_valid", w_out_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream: vector n shows up two negedges after it is driven.
        for (int n = 0; n < NV + 2; n++) begin
            @(negedge clk);
            chk("stream.in_ready", in_ready, 1);
            if (n >= 2) expect_out($sformatf("vec%0d", n - 2), vt[n-2].count, vt[n-2].tag, vt[n-2].all);
            else chk("stream.fill_valid", out_valid, 0);
            if (n < NV) drive(1'b1, vt[n].op, vt[n].value, vt[n].tag);
            else drive(1'b0, 2'd0, 32'h0, 5'd0);
        end
        @(negedge clk);
        chk("stream.drain_valid", out_valid, 0);

        for (int n = 0; n < NV64 + 2; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                chk($sformatf("w%0d.valid", n - 2), w_out_valid, 1);
                chk($sformatf("w%0d.count", n - 2), w_count, wt[n-2].count);
                chk($sformatf("w%0d.tag", n - 2), w_out_tag, wt[n-2].tag);
                chk($sformatf("w%0d.all", n - 2), w_all, wt[n-2].all);
            end
            if (n < NV64) begin
                w_valid = 1'b1; w_op = wt[n].op; w_value = wt[n].value; w_tag = wt[n].tag;
            end else begin
                w_valid = 1'b0;
            end
        end

        // Backpressure: three ops against a stalled consumer.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'h0000_0F00, 5'd20);
        @(negedge clk);
        chk("bp.in_ready_one_held", in_ready, 1);
        drive(1'b1, 2'd3, 32'h0000_FFFF, 5'd21);
        @(negedge clk);
        drive(1'b1, 2'd2, 32'h0000_0010, 5'd22);
        for (int k = 0; k < 4; k++) begin
            chk("bp.in_ready_full", in_ready, 0);
            expect_out("bp.hold", 6'd20, 5'd20, 1'b0);
            @(negedge clk);
        end
        expect_out("bp.first", 6'd20, 5'd20, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        expect_out("bp.second", 6'd16, 5'd21, 1'b0);
        drive(1'b0, 2'd0, 32'h0, 5'd0);
        @(negedge clk);
        expect_out("bp.third", 6'd4, 5'd22, 1'b0);
        @(negedge clk);
        chk("bp.drained", out_valid, 0);

        // Flush with two ops in flight and a third presented.
        drive(1'b1, 2'd0, 32'h0000_0001, 5'd3);
        @(negedge clk);
        drive(1'b1, 2'd1, 32'hFFFF_0000, 5'd4);
        @(negedge clk);
        expect_out("fl.before", 6'd31, 5'd3, 1'b0);
        drive(1'b1, 2'd3, 32'hFFFF_FFFF, 5'd7);
        flush = 1'b1;
        #1;
        chk("fl.in_ready_low", in_ready, 0);
        @(negedge clk);
        chk("fl.out_cleared", out_valid, 0);
        flush = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 5'd0);
        @(negedge clk);
        chk("fl.s1_empty", out_valid, 0);
        drive(1'b1, 2'd3, 32'h1234_5678, 5'd9);
        @(negedge clk);
        chk("fl.latency", out_valid, 0);
        drive(1'b0, 2'd0, 32'h0, 5'd0);
        @(negedge clk);
        expect_out("fl.after", 6'd13, 5'd9, 1'b0);

        // Asynchronous reset between clock edges with ops in flight.
        drive(1'b1, 2'd1, 32'hFF00_0000, 5'd5);
        @(negedge clk);
        drive(1'b1, 2'd0, 32'h0000_0003, 5'd6);
        @(negedge clk);
        expect_out("ar.before", 6'd8, 5'd5, 1'b0);
        drive(1'b0, 2'd0, 32'h0, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.out_valid_async", out_valid, 0);
        chk("ar.out_count_async", out_count, 0);
        @(negedge clk);
        chk("ar.in_ready", in_ready, 1);
        chk("ar.held_valid", out_valid, 0);
        rst = 1'b0;
        drive(1'b1, 2'd0, 32'h0001_0000, 5'd14);
        @(negedge clk);
        chk("ar.latency", out_valid, 0);
        drive(1'b0, 2'd0, 32'h0, 5'd0);
        @(negedge clk);
        expect_out("ar.first", 6'd15, 5'd14, 1'b0);
        @(negedge clk);
        chk("ar.drained", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_count_pipe.md
Name: bit_count_pipe

Overview:
- Parametrised, two-stage pipelined bit-counting unit for the EXE stage. Successor to the single-cycle CLZ/CLO counter.
- Supports four operations: count leading zeros, count leading ones, count trailing zeros, and population count, at configurable operand width.
- Uses a valid/ready handshake on both sides and a flush input, so it can sit behind the EXE issue logic and stall or cancel with the pipeline.

Parameters:
- WIDTH, 32, operand width in bits; power of two, minimum 8.
- GROUP, 8, bits per first-stage group; power of two, must divide WIDTH.
- CW, $clog2(WIDTH)+1, result width (derived, not overridable); holds 0..WIDTH.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous kill of all in-flight operations
- in_valid  input  1  operand/op valid
- in_ready  output  1  unit can accept an operand this cycle
- in_op  input  2  00 CLZ, 01 CLO, 10 CTZ, 11 POPCNT
- in_value  input  WIDTH  operand
- in_tag  input  5  destination register tag, carried unchanged
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_count  output  CW  result count
- out_tag  output  5  tag of the result
- out_all  output  1  result equals WIDTH (operand all-0 for CLZ/CTZ, all-1 for CLO/POPCNT)

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_count=0, out_tag=0, out_all=0, in_ready=1.
- Stage 1 (S1), on accept:
  - Normalise the operand. CLO and POPCNT-of-ones use the value as is; CLZ inverts it so every op counts ones or leading ones.
  - CTZ bit-reverses the operand, then handles it as CLZ.
  - Split into N=WIDTH/GROUP groups. Per group, register the leading-run count (0..GROUP) and the popcount (0..GROUP).
  - Also register op and tag.
- Stage 2 (S2):
  - Leading ops: the result is the sum of group run counts from the MSB group down to and including the first group whose run count is < GROUP.
  - POPCNT: the result is the sum of all group popcounts.
  - Register out_count, out_tag, and out_all = (out_count==WIDTH).
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput is 1 per cycle.
- Accept: occurs when in_valid && in_ready.
- Backpressure:
  - S2 advance = !s2_valid || out_ready.
  - S1 advance = !s1_valid || S2 advance.
  - in_ready = S1 advance (combinational, no dependence on in_valid).
- Hold: while out_valid && !out_ready, out_count/out_tag/out_all are held stable. A full pipeline holds both stages; nothing is dropped or duplicated.
- Flush:
  - On the clock edge with flush=1, s1_valid and s2_valid are cleared, regardless of out_ready.
  - Any input presented that same cycle is discarded.
  - in_ready is forced to 0 while flush=1.
  - Data registers may keep stale values; out_valid=0 makes them don't-care.
- Simultaneous events:
  - Flush has priority over accept and over output transfer.
  - Accept and output transfer in the same cycle are both legal; the pipeline moves forward by one.
- Reset mid-operation: all valids drop immediately (asynchronously). After release, the first accepted operand produces out_valid exactly 2 cycles later.
- Arithmetic: all adds are unsigned at CW bits and cannot overflow. The result never exceeds WIDTH.
- Boundaries:
  - All-zero operand: CLZ=WIDTH, CTZ=WIDTH, CLO=0, POPCNT=0.
  - All-ones operand: CLO=WIDTH, POPCNT=WIDTH, CLZ=0, CTZ=0.
- Legality: in_op is sampled only on accept. Invalid cycles have no side effects.

Test Plan:
- WIDTH=32, back-to-back accepts with out_ready=1:
  - CLZ 0x0000_8000 -> 16
  - CLO 0xFFF0_0000 -> 12
  - CTZ 0x0000_0100 -> 8
  - POPCNT 0xF0F0_F0F0 -> 16
  - Results appear on consecutive cycles, 2 cycles after each accept, with tags preserved in order.
- Boundaries, WIDTH=32:
  - CLZ 0 -> 32, out_all=1
  - CLO 0xFFFF_FFFF -> 32, out_all=1
  - CTZ 0x8000_0000 -> 31
  - POPCNT 0 -> 0, out_all=0
- Backpressure: issue 3 ops, hold out_ready=0 for 4 cycles.
  - in_ready falls after 2 ops are held.
  - out_count stays stable while held.
  - Releasing out_ready delivers all 3 results in order with no loss.
- Flush: with 2 ops in flight plus in_valid=1, assert flush for 1 cycle.
  - Next cycle out_valid=0 and s1 is empty.
  - An op accepted after the flush returns its correct result 2 cycles later.
- Async reset: assert rst between clock edges with ops in flight.
  - out_valid drops without waiting for a clock edge.
  - After release, in_ready=1 and the first result arrives at latency 2.
- Parametrisation: WIDTH=64, GROUP=8.
  - CLZ 0x0000_0000_0000_0001 -> 63
  - POPCNT all-ones -> 64 (CW=7)
